// File: rtl/mod_addsub_pipe.sv
// -----------------------------------------------------------------------------
// mod_addsub_pipe
//
// Two-stage pipelined modular add/subtract unit for rotor-offset arithmetic.
// Computes (a - b) mod MODULUS (in_op = 0) or (a + b) mod MODULUS (in_op = 1).
// A plain decrement is issued as a subtract with b = 1.
//
// Parameters
//   WIDTH    operand/result width in bits (MODULUS <= 2**WIDTH)
//   MODULUS  modulus applied to every result (>= 2)
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      unit accepts a beat this cycle
//   in_op      in   1      0 = subtract (a - b), 1 = add (a + b)
//   in_a       in   WIDTH  operand a, expected < MODULUS
//   in_b       in   WIDTH  operand b, expected < MODULUS
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts the result
//   out_data   out  WIDTH  result, < MODULUS for in-range operands
//   out_err    out  1      operand range error flag, travels with its beat
//
// Build option
//   MOD_ADDSUB_RANGE_CHK_EN  when defined, stage 1 flags operands >= MODULUS,
//                            the flag rides along to out_err and forces
//                            out_data to 0. When undefined no comparators are
//                            built and out_err is constant 0. Latency and
//                            timing are the same either way.
//
// Handshake
//   A beat transfers on a rising edge where valid & ready are both high.
//   valid never depends on ready. While out_valid & ~out_ready the output
//   beat (out_data, out_err) is held stable. in_ready is combinational from
//   out_ready (no skid buffer): a stage may load when it is empty or when
//   the stage after it is draining in the same cycle.
// -----------------------------------------------------------------------------
module mod_addsub_pipe #(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   // Modulus in the widened (WIDTH+1) domain used for the stage-1 sum, and in
   // the result domain. When MODULUS == 2**WIDTH the narrow copy is 0, which
   // is still correct because adding 2**WIDTH is a no-op modulo 2**WIDTH.
   localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MODULUS);

   // ---------------------------------------------------------------------------
   // Pipeline state
   // ---------------------------------------------------------------------------
   logic             s1_v_q,   s1_v_d;
   logic [WIDTH:0]   s1_sum_q, s1_sum_d;
   logic             s1_op_q,  s1_op_d;

   logic             s2_v_q,    s2_v_d;
   logic [WIDTH-1:0] s2_data_q, s2_data_d;

   logic             s1_en;
   logic             s2_en;

   // ---------------------------------------------------------------------------
   // Stage enables
   // ---------------------------------------------------------------------------
   assign s2_en    = ~s2_v_q | out_ready;
   assign s1_en    = ~s1_v_q | s2_en;
   assign in_ready = s1_en;

   // ---------------------------------------------------------------------------
   // Stage 1: widened add / two's-complement subtract
   // ---------------------------------------------------------------------------
   logic [WIDTH:0] s1_b_x;
   logic [WIDTH:0] s1_cin;

   always_comb begin
      s1_b_x   = '0;
      s1_cin   = '0;
      s1_v_d   = s1_v_q;
      s1_sum_d = s1_sum_q;
      s1_op_d  = s1_op_q;

      // For subtract, ~{1'b0,b} + 1 is the WIDTH+1-bit negation of b.
      s1_b_x = in_op ? {1'b0, in_b} : {1'b1, ~in_b};
      s1_cin = {{WIDTH{1'b0}}, ~in_op};

      if (s1_en) begin
         s1_v_d = in_valid;
         if (in_valid) begin
            s1_sum_d = {1'b0, in_a} + s1_b_x + s1_cin;
            s1_op_d  = in_op;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: modular correction
   // ---------------------------------------------------------------------------
   // For subtract the extra top bit is the sign of (a - b): it reads 1 exactly
   // when a < b, i.e. when the carry out of the WIDTH-bit add was 0 (borrow).
   // In that case the low bits hold a - b + 2**WIDTH, and adding MODULUS with
   // truncation yields a - b + MODULUS.
   logic             s1_borrow;
   logic [WIDTH:0]   s2_add_red;
   logic [WIDTH-1:0] s2_res;

   assign s1_borrow  = s1_sum_q[WIDTH];
   assign s2_add_red = s1_sum_q - MOD_X;

   always_comb begin
      s2_res = s1_sum_q[WIDTH-1:0];
      if (s1_op_q) begin
         if (s1_sum_q >= MOD_X) begin
            s2_res = s2_add_red[WIDTH-1:0];
         end
      end else if (s1_borrow) begin
         s2_res = s1_sum_q[WIDTH-1:0] + MOD_W;
      end
   end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
   // ---------------------------------------------------------------------------
   // Operand range check (optional)
   // ---------------------------------------------------------------------------
   logic s1_err_q, s1_err_d;
   logic s2_err_q, s2_err_d;

   always_comb begin
      s1_err_d = s1_err_q;
      if (s1_en && in_valid) begin
         s1_err_d = ({1'b0, in_a} >= MOD_X) | ({1'b0, in_b} >= MOD_X);
      end
   end

   always_comb begin
      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      s2_err_d  = s2_err_q;
      if (s2_en) begin
         s2_v_d = s1_v_q;
         // An empty stage 1 leaves the last result on the bus.
         if (s1_v_q) begin
            s2_data_d = s1_err_q ? '0 : s2_res;
            s2_err_d  = s1_err_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_err_q <= 1'b0;
         s2_err_q <= 1'b0;
      end else begin
         s1_err_q <= s1_err_d;
         s2_err_q <= s2_err_d;
      end
   end

   assign out_err = s2_err_q;
`else
   always_comb begin
      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      if (s2_en) begin
         s2_v_d = s1_v_q;
         // An empty stage 1 leaves the last result on the bus.
         if (s1_v_q) begin
            s2_data_d = s2_res;
         end
      end
   end

   assign out_err = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_sum_q  <= '0;
         s1_op_q   <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_sum_q  <= s1_sum_d;
         s1_op_q   <= s1_op_d;
         s2_v_q    <= s2_v_d;
         s2_data_q <= s2_data_d;
      end
   end

   assign out_valid = s2_v_q;
   assign out_data  = s2_data_q;

endmodule
